// File: rtl/mavg_seq_ctrl.sv
// mavg_seq_ctrl: sequencer for the 3-tap moving-average datapath.
// Accepts samples over valid/ready. Drives the datapath shift-load and clear
// controls and tracks how full the window is. Once the window is full it
// captures the datapath sum and presents it downstream with backpressure.
//
// Build option: define MAVG_CTRL_DECIM_EN for block-average mode with
// decimation TAPS. Each result then needs TAPS fresh samples, and RUN is
// never entered. Without the macro, every accept in RUN produces one result
// (sliding window).
module mavg_seq_ctrl #(
    parameter int DW    = 8,   // sample width, signed
    parameter int TAPS  = 3,   // window length, >= 2
    parameter int SW    = 10,  // sum width, >= DW + $clog2(TAPS)
    parameter int CNT_W = 2    // fill-counter width, >= $clog2(TAPS+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 flush,
    output logic                 dp_load,
    output logic                 dp_clr,
    output logic [DW-1:0]        dp_num,
    input  logic [SW-1:0]        dp_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_sum,
    output logic [CNT_W-1:0]     fill_cnt
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,  // window not yet full
        ST_CAPT = 2'd1,  // datapath sum settles; capture it
        ST_HOLD = 2'd2,  // result presented downstream
        ST_RUN  = 2'd3   // window full, waiting for the next sample
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   take;

    // Handshake and datapath controls. While reset is asserted, in_ready and
    // dp_clr are forced low.
    always_comb begin
        in_ready = rst_n && !flush && (state == ST_FILL || state == ST_RUN);
        accept   = in_valid && in_ready;
        take     = (state == ST_HOLD) && out_ready;
        dp_load  = accept;
        dp_clr   = rst_n && flush;
        dp_num   = in_data;
    end

    // Next-state logic. Flush overrides every other event.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: if (accept && fill_cnt == CNT_LAST) state_nxt = ST_CAPT;
                ST_RUN:  if (accept) state_nxt = ST_CAPT;
                ST_CAPT: state_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (out_ready) begin
`ifdef MAVG_CTRL_DECIM_EN
                        state_nxt = ST_FILL;
`else
                        state_nxt = ST_RUN;
`endif
                    end
                end
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values, whatever order the blocks evaluate in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FILL;
        else        state <= state_nxt;
    end

    // Window fill counter. It saturates at TAPS because it only counts in
    // FILL. In decimation mode it reloads when a result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (flush) begin
            fill_cnt <= '0;
        end else if (state == ST_FILL && accept) begin
            fill_cnt <= fill_cnt + CNT_ONE;
        end else if (take) begin
`ifdef MAVG_CTRL_DECIM_EN
            fill_cnt <= '0;
`else
            fill_cnt <= fill_cnt;
`endif
        end
    end

    // Result register. It captures dp_sum bit-exact in CAPT and holds it
    // until the downstream takes it. A flush discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (state == ST_CAPT) begin
            out_valid <= 1'b1;
            out_sum   <= dp_sum;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mavg_seq_ctrl.sv
// Testbench for mavg_seq_ctrl. A small shift-register-plus-adder stands in
// for the datapath. Expected sums and fill counts come from a queue-based
// model of the accepted samples.
module tb_mavg_seq_ctrl;

    localparam int DW    = 8;
    localparam int TAPS  = 3;
    localparam int SW    = 10;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              flush;
    logic              dp_load;
    logic              dp_clr;
    logic [DW-1:0]     dp_num;
    logic [SW-1:0]     dp_sum;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_sum;
    logic [CNT_W-1:0]  fill_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mavg_seq_ctrl #(.DW(DW), .TAPS(TAPS), .SW(SW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .dp_load   (dp_load),
        .dp_clr    (dp_clr),
        .dp_num    (dp_num),
        .dp_sum    (dp_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .fill_cnt  (fill_cnt)
    );

    // Passive datapath: TAPS-deep shift register plus a signed adder.
    logic signed [DW-1:0] taps_r [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) taps_r[i] <= '0;
        end else if (dp_clr) begin
            for (int i = 0; i < TAPS; i++) taps_r[i] <= '0;
        end else if (dp_load) begin
            taps_r[0] <= dp_num;
            for (int i = 1; i < TAPS; i++) taps_r[i] <= taps_r[i-1];
        end
    end

    always_comb begin
        dp_sum = '0;
        for (int i = 0; i < TAPS; i++) dp_sum = dp_sum + SW'(taps_r[i]);
    end

    // Reference model: samples accepted since the last clear, and samples
    // counted toward the current decimation block.
    int win[$];
    int since_reload = 0;

    function automatic bit result_due();
`ifdef MAVG_CTRL_DECIM_EN
        return since_reload == TAPS;
`else
        return win.size() >= TAPS;
`endif
    endfunction

    function automatic int model_sum();
        int s = 0;
        for (int i = win.size() - TAPS; i < win.size(); i++) s += win[i];
        return s;
    endfunction

    function automatic int model_fill();
`ifdef MAVG_CTRL_DECIM_EN
        return since_reload;
`else
        return (win.size() < TAPS) ? win.size() : TAPS;
`endif
    endfunction

    function automatic void model_clear();
        win.delete();
        since_reload = 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sample from just after a negedge; it is accepted at the next
    // posedge. If a result is due, follow it through CAPT and HOLD. HOLD
    // can be stalled for 'hold' cycles (optionally with a new sample waiting)
    // or ended by a flush. Returns just after a negedge.
    task automatic push(input int s, input int hold = 0, input bit stall_valid = 1'b0,
                        input int stall_data = 0, input bit flush_hold = 1'b0);
        logic [DW-1:0] sd;
        logic [SW-1:0] e;
        sd = DW'(s);
        in_valid  = 1'b1;
        in_data   = sd;
        out_ready = (hold == 0) && !flush_hold;
        #1;
        check("in_ready_offer", 32'(in_ready), 32'(1'b1));
        check("dp_load_offer", 32'(dp_load), 32'(1'b1));
        check("dp_num", 32'(dp_num), 32'(sd));
        @(negedge clk);
        in_valid = 1'b0;
        win.push_back(int'($signed(sd)));
        since_reload++;
        check("fill_after_accept", 32'(fill_cnt), 32'(model_fill()));
        check("out_valid_after_accept", 32'(out_valid), 32'(1'b0));
        if (!result_due()) return;
        check("in_ready_capt", 32'(in_ready), 32'(1'b0));
        e = SW'(model_sum());
        @(negedge clk);
        check("out_valid_hold", 32'(out_valid), 32'(1'b1));
        check("out_sum", 32'(out_sum), 32'(e));
        check("in_ready_hold", 32'(in_ready), 32'(1'b0));
        if (flush_hold) begin
            flush     = 1'b1;
            in_valid  = 1'b1;
            in_data   = DW'($urandom);
            out_ready = 1'b1;
            #1;
            check("dp_clr_flush", 32'(dp_clr), 32'(1'b1));
            check("in_ready_flush", 32'(in_ready), 32'(1'b0));
            check("dp_load_flush", 32'(dp_load), 32'(1'b0));
            @(negedge clk);
            flush     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            model_clear();
            check("out_valid_flushed", 32'(out_valid), 32'(1'b0));
            check("fill_flushed", 32'(fill_cnt), 32'(0));
            #1;
            check("dp_clr_after_flush", 32'(dp_clr), 32'(1'b0));
            check("in_ready_after_flush", 32'(in_ready), 32'(1'b1));
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = stall_valid;
            in_data  = DW'(stall_data);
            #1;
            check("in_ready_stall", 32'(in_ready), 32'(1'b0));
            check("dp_load_stall", 32'(dp_load), 32'(1'b0));
            @(negedge clk);
            check("out_valid_stall", 32'(out_valid), 32'(1'b1));
            check("out_sum_stall", 32'(out_sum), 32'(e));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`ifdef MAVG_CTRL_DECIM_EN
        since_reload = 0;
`endif
        check("out_valid_taken", 32'(out_valid), 32'(1'b0));
        check("fill_after_take", 32'(fill_cnt), 32'(model_fill()));
        check("in_ready_after_take", 32'(in_ready), 32'(1'b1));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1'b0));
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_out_sum", 32'(out_sum), 32'(0));
        check("rst_fill", 32'(fill_cnt), 32'(0));
        check("rst_dp_clr", 32'(dp_clr), 32'(1'b0));
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Fill the window, then slide.
        push(10);
        push(20);
        push(30);
        push(40);
        push(50, 5, 1'b1, 70);
        push(70);

        // Extremes of the signed range.
        push(-128); push(-128); push(-128);
        push(127);  push(127);  push(127);

        // Flush while a result is held with out_ready high.
        push(5, 0, 1'b0, 0, 1'b1);
        push(1); push(2); push(3);

        // Async reset between edges with two samples in the window.
        model_clear();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push(7);
        push(8);
        check("fill_before_async", 32'(fill_cnt), 32'(2));
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'(1'b0));
        check("async_fill", 32'(fill_cnt), 32'(0));
        check("async_in_ready", 32'(in_ready), 32'(1'b0));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        model_clear();
        push(1); push(2); push(4);

        // Multi-cycle flush with a sample waiting.
        push(9);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd33;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mflush_dp_clr", 32'(dp_clr), 32'(1'b1));
            check("mflush_in_ready", 32'(in_ready), 32'(1'b0));
            check("mflush_dp_load", 32'(dp_load), 32'(1'b0));
            @(negedge clk);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check("mflush_fill", 32'(fill_cnt), 32'(0));
        push(1); push(1); push(1);

        // Random samples with random backpressure and occasional flushes.
        for (int n = 0; n < 40; n++) begin
            push(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
                 1'b0, 0, ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
